// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS receive channel: word alignment via control-token runs, lock tracking, decode
// Stage 1 registers the raw word; stage 2 holds the FSM and all registered outputs.

module tmds_channel_decoder #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int SLIP_WAIT      = 4,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       pixclk,
  input  logic       rst_n,
  input  logic [9:0] tmds_in,
  output logic       bitslip,
  output logic [7:0] VD,
  output logic [1:0] CD,
  output logic       VDE,
  output logic       locked
);

  localparam int M1   = (CTRL_RUN > SLIP_WAIT) ? CTRL_RUN : SLIP_WAIT;
  localparam int M2   = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int MAXP = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] RUN_LOCK  = CW'(CTRL_RUN);
  localparam logic [CW-1:0] TMO_LAST  = CW'(SEARCH_TIMEOUT - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(SLIP_WAIT - 1);
  localparam logic [CW-1:0] LOSS_DROP = CW'(LOSS_TIMEOUT);

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  // Pure datapath stage; it keeps sampling during reset so the word in flight at release is real input.
  logic [9:0] w_q;
  always_ff @(posedge pixclk) begin
    w_q <= tmds_in;
  end

  logic       is_tok;
  logic [1:0] tok_cd;
  logic [7:0] q_w;
  logic [7:0] dec;

  always_comb begin
    is_tok = 1'b1;
    tok_cd = 2'b00;
    case (w_q)
      10'b1101010100: tok_cd = 2'b00;
      10'b0010101011: tok_cd = 2'b01;
      10'b0101010100: tok_cd = 2'b10;
      10'b1010101011: tok_cd = 2'b11;
      default:        is_tok = 1'b0;
    endcase
    q_w    = w_q[9] ? ~w_q[7:0] : w_q[7:0];
    dec    = '0;
    dec[0] = q_w[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = w_q[8] ? (q_w[i] ^ q_w[i-1]) : ~(q_w[i] ^ q_w[i-1]);
    end
  end

  state_t        state_q, state_d;
  logic [CW-1:0] run_q, run_d, tmo_q, tmo_d, wait_q, wait_d, loss_q, loss_d;
  logic          slip_d, lock_d, vde_d;
  logic [7:0]    vd_d;
  logic [1:0]    cd_d;
  logic          bitslip_q, vde_q, locked_q;
  logic [7:0]    vd_q;
  logic [1:0]    cd_q;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    tmo_d   = tmo_q;
    wait_d  = wait_q;
    loss_d  = loss_q;
    slip_d  = 1'b0;
    lock_d  = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        run_d = is_tok ? sat_inc(run_q) : '0;
        tmo_d = sat_inc(tmo_q);
        // Lock is checked first so a run completing on the timeout cycle never slips.
        if (run_d == RUN_LOCK) begin
          state_d = ST_LOCKED;
          lock_d  = 1'b1;
          run_d   = '0;
          tmo_d   = '0;
          loss_d  = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_SLIP_WAIT;
          slip_d  = 1'b1;
          run_d   = '0;
          tmo_d   = '0;
          wait_d  = '0;
        end
      end
      ST_SLIP_WAIT: begin
        wait_d = sat_inc(wait_q);
        if (wait_q == WAIT_LAST) begin
          state_d = ST_SEARCH;
          wait_d  = '0;
          run_d   = '0;
          tmo_d   = '0;
        end
      end
      ST_LOCKED: begin
        lock_d = 1'b1;
        loss_d = is_tok ? '0 : sat_inc(loss_q);
        if (loss_d == LOSS_DROP) begin
          state_d = ST_SEARCH;
          lock_d  = 1'b0;
          loss_d  = '0;
          run_d   = '0;
          tmo_d   = '0;
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    vde_d = 1'b0;
    vd_d  = '0;
    cd_d  = '0;
    if (lock_d) begin
      cd_d = is_tok ? tok_cd : cd_q;
      if (!is_tok) begin
        vde_d = 1'b1;
        vd_d  = dec;
      end
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SEARCH;
      run_q     <= '0;
      tmo_q     <= '0;
      wait_q    <= '0;
      loss_q    <= '0;
      bitslip_q <= 1'b0;
      vd_q      <= '0;
      cd_q      <= '0;
      vde_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      tmo_q     <= tmo_d;
      wait_q    <= wait_d;
      loss_q    <= loss_d;
      bitslip_q <= slip_d;
      vd_q      <= vd_d;
      cd_q      <= cd_d;
      vde_q     <= vde_d;
      locked_q  <= lock_d;
    end
  end

  assign bitslip = bitslip_q;
  assign VD      = vd_q;
  assign CD      = cd_q;
  assign VDE     = vde_q;
  assign locked  = locked_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - directed scoreboard bench for tmds_channel_decoder
// A second instance with a short search timeout covers the lock/timeout collision.

module tb_tmds_channel_decoder;

  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T1 = 10'b0010101011;
  localparam logic [9:0] T2 = 10'b0101010100;
  localparam logic [9:0] T3 = 10'b1010101011;
  localparam logic [9:0] D1 = 10'b0100000000;
  localparam logic [9:0] D2 = 10'b1011111111;

  logic       pixclk = 1'b0;
  logic       rst_n  = 1'b1;
  logic       rst_nb = 1'b0;
  logic [9:0] tmds_in = T0;
  logic [9:0] tmds_b  = T0;
  logic       bitslip, VDE, locked;
  logic [7:0] VD;
  logic [1:0] CD;
  logic       bitslip_b, VDE_b, locked_b;
  logic [7:0] VD_b;
  logic [1:0] CD_b;

  always #5 pixclk = ~pixclk;

  tmds_channel_decoder u_dut (
    .pixclk(pixclk), .rst_n(rst_n), .tmds_in(tmds_in), .bitslip(bitslip),
    .VD(VD), .CD(CD), .VDE(VDE), .locked(locked)
  );

  tmds_channel_decoder #(.SEARCH_TIMEOUT(8)) u_dut_b (
    .pixclk(pixclk), .rst_n(rst_nb), .tmds_in(tmds_b), .bitslip(bitslip_b),
    .VD(VD_b), .CD(CD_b), .VDE(VDE_b), .locked(locked_b)
  );

  typedef struct packed {
    logic       lk;
    logic       vde;
    logic [1:0] cd;
    logic [7:0] vd;
    logic       bs;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   slips_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic exp_t e_off();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t e_tok(input logic [1:0] cd);
    exp_t e;
    e = '0;
    e.lk = 1'b1;
    e.cd = cd;
    return e;
  endfunction

  function automatic exp_t e_dat(input logic [7:0] vd, input logic [1:0] cd);
    exp_t e;
    e = '0;
    e.lk  = 1'b1;
    e.vde = 1'b1;
    e.cd  = cd;
    e.vd  = vd;
    return e;
  endfunction

  function automatic logic is_tok_ref(input logic [9:0] w);
    return (w == T0) || (w == T1) || (w == T2) || (w == T3);
  endfunction

  function automatic logic [1:0] tok_cd_ref(input logic [9:0] w);
    if (w == T1) return 2'b01;
    if (w == T2) return 2'b10;
    if (w == T3) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [7:0] dec_ref(input logic [9:0] w);
    logic [7:0] q, d;
    q    = w[7:0] ^ {8{w[9]}};
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = q[i] ^ q[i-1] ^ ~w[8];
    return d;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    do w = 10'($urandom_range(0, 1023)); while (is_tok_ref(w));
    return w;
  endfunction

  function automatic logic [9:0] rotr(input logic [9:0] w, input int r);
    logic [19:0] dbl;
    dbl = {w, w} >> r;
    return dbl[9:0];
  endfunction

  task automatic step(input logic [9:0] w, input exp_t e);
    exp_t x;
    tmds_in = w;
    sb.push_back(e);
    @(posedge pixclk);
    #1;
    if (bitslip) slips_seen++;
    x = sb.pop_front();
    chk("locked", 32'(locked), 32'(x.lk));
    chk("VDE", 32'(VDE), 32'(x.vde));
    chk("CD", 32'(CD), 32'(x.cd));
    chk("VD", 32'(VD), 32'(x.vd));
    chk("bitslip", 32'(bitslip), 32'(x.bs));
  endtask

  // Reset lands between edges; the word held on tmds_in is in stage 1 at release.
  task automatic do_reset(input logic [9:0] w);
    tmds_in = w;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_VDE", 32'(VDE), 32'd0);
    chk("rst_VD", 32'(VD), 32'd0);
    chk("rst_CD", 32'(CD), 32'd0);
    chk("rst_bitslip", 32'(bitslip), 32'd0);
    repeat (2) @(posedge pixclk);
    #3 rst_n = 1'b1;
    sb.delete();
    sb.push_back(e_off());
  endtask

  initial begin
    logic [9:0] w;
    logic [1:0] cd_last;
    exp_t       e;
    int         off;
    int         bs_b;

    // Aligned blanking: the 8th token raises lock.
    do_reset(T0);
    for (int i = 2; i <= 10; i++) step(T0, (i >= 8) ? e_tok(2'b00) : e_off());

    // Decode of fixed and random words; CD holds across data.
    step(D1, e_dat(8'h00, 2'b00));
    step(D2, e_dat(8'hFE, 2'b00));
    step(T1, e_tok(2'b01));
    cd_last = 2'b01;
    for (int i = 0; i < 16; i++) begin
      w = 10'($urandom_range(0, 1023));
      if (is_tok_ref(w)) begin
        cd_last = tok_cd_ref(w);
        step(w, e_tok(cd_last));
      end else begin
        step(w, e_dat(dec_ref(w), cd_last));
      end
    end
    step(T3, e_tok(2'b11));
    step(T2, e_tok(2'b10));
    step(D1, e_dat(8'h00, 2'b10));
    step(T0, e_tok(2'b00));

    // Loss of lock after LOSS_TIMEOUT data words, then relock.
    slips_seen = 0;
    for (int k = 1; k <= 4096; k++) begin
      w = rand_data();
      step(w, (k < 4096) ? e_dat(dec_ref(w), 2'b00) : e_off());
    end
    for (int k = 0; k < 3; k++) step(rand_data(), e_off());
    for (int k = 1; k <= 9; k++) step(T2, (k >= 8) ? e_tok(2'b10) : e_off());
    chk("loss_no_slip", 32'(slips_seen), 32'd0);

    // Misaligned by 3 bits; the deserializer model slips on each pulse.
    off = 3;
    do_reset(rotr(T0, 3));
    slips_seen = 0;
    for (int s = 1; s <= 3095; s++) begin
      e = (s >= 3091) ? e_tok(2'b00) : e_off();
      if (s == 1023 || s == 2051 || s == 3079) e.bs = 1'b1;
      step(rotr(T0, off), e);
      if (bitslip && off > 0) off--;
    end
    chk("slip_count", 32'(slips_seen), 32'd3);

    // Asynchronous reset while locked with live outputs.
    step(T3, e_tok(2'b11));
    step(D2, e_dat(8'hFE, 2'b11));
    step(D1, e_dat(8'h00, 2'b11));
    do_reset(T1);
    for (int i = 2; i <= 9; i++) step(T1, (i >= 8) ? e_tok(2'b01) : e_off());

    // Lock and timeout coincide on the 8th search cycle of the short-timeout instance.
    bs_b = 0;
    @(posedge pixclk);
    #3 rst_nb = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(posedge pixclk);
      #1;
      if (bitslip_b) bs_b++;
      chk("collide_locked", 32'(locked_b), (j >= 8) ? 32'd1 : 32'd0);
    end
    chk("collide_no_slip", 32'(bs_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the per-channel TMDS encoder, one instance per colour channel.
- Sits after a 1:10 deserializer.
- Takes raw 10-bit words at pixel rate, finds word alignment by hunting for runs of TMDS control tokens, and drives a one-cycle bitslip request to the deserializer until aligned.
- Once locked, decodes 8-bit video data or 2-bit control data and regenerates VD/CD/VDE for downstream timing recovery.

Parameters:
- CTRL_RUN, 8: consecutive control tokens required to declare lock.
- SEARCH_TIMEOUT, 1024: pixclk cycles spent in SEARCH before a bitslip is issued.
- SLIP_WAIT, 4: cycles after a bitslip during which input is ignored.
- LOSS_TIMEOUT, 4096: cycles without any control token, while locked, before lock is dropped.

Ports:
- pixclk  input  1  pixel clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- tmds_in  input  10  raw word from the deserializer; bit numbering identical to the encoder's TMDS output.
- bitslip  output  1  one-cycle pulse requesting the deserializer shift its word boundary by one bit.
- VD  output  8  decoded video data.
- CD  output  2  decoded control bits.
- VDE  output  1  high when VD is valid video.
- locked  output  1  word alignment achieved.

Behaviour:
- Reset (async assert, sync release): FSM = SEARCH; all counters 0; bitslip=0, VD=0, CD=0, VDE=0, locked=0. Reset mid-operation drops lock immediately.
- Input register: tmds_in is registered once (stage 1). All token compare and decode work uses the stage-1 word.
- Output register: VD/CD/VDE/locked are registered (stage 2). Latency from tmds_in to outputs is exactly 2 pixclk.
- Control tokens:
  - 10'b1101010100 -> CD=00
  - 10'b0010101011 -> CD=01
  - 10'b0101010100 -> CD=10
  - 10'b1010101011 -> CD=11
- Data decode:
  - q = w[9] ? ~w[7:0] : w[7:0]
  - D[0] = q[0]
  - D[i] = w[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]), for i = 1..7
- FSM state SEARCH:
  - run_cnt increments on each token word; any non-token word clears it.
  - tmo_cnt increments every cycle.
  - When run_cnt reaches CTRL_RUN: go to LOCKED.
  - Else when tmo_cnt reaches SEARCH_TIMEOUT-1: pulse bitslip for one cycle, clear both counters, go to SLIP_WAIT.
  - If lock and timeout occur in the same cycle, lock wins and no bitslip is issued.
- FSM state SLIP_WAIT:
  - Input is ignored; bitslip=0.
  - After SLIP_WAIT cycles, return to SEARCH with counters cleared.
- FSM state LOCKED:
  - locked=1 (visible at stage 2).
  - loss_cnt clears on any token word and increments otherwise.
  - When loss_cnt reaches LOSS_TIMEOUT: go to SEARCH, locked=0, counters cleared. No bitslip is issued on loss.
- Outputs while locked:
  - Token word: VDE=0, CD=token value, VD=0.
  - Non-token word: VDE=1, VD=decoded D, CD holds its last value.
- Outputs while not locked: VDE=0, CD=00, VD=0 regardless of input.
- bitslip is never high on two consecutive cycles and never high outside the SEARCH->SLIP_WAIT transition.
- Counters saturate and never wrap. Width is sized with $clog2 of the largest relevant parameter, plus 1.

Test Plan:
- Lock on aligned blanking: reset, then feed 10'b1101010100 continuously. Required: locked=1 at stage 2 on the cycle after the 8th token, CD=00, VDE=0, bitslip never asserted.
- Data decode: locked, feed 10'b0100000000 then 10'b1011111111. Required: two cycles later VD=8'h00 with VDE=1, then VD=8'hFE with VDE=1; CD keeps the last token value.
- Misalignment: deserializer model rotates the token stream by 3 bits; each bitslip pulse reduces the offset by 1. Required: exactly 3 bitslip pulses, each 1024 search cycles plus 4 wait cycles apart, then locked=1.
- Lock vs timeout collision: SEARCH_TIMEOUT=8 with the 8th token landing on the timeout cycle. Required: lock, no bitslip.
- Loss of lock: locked, then feed only data words for 4096 cycles. Required: locked falls to 0, VDE=0, VD=0, no bitslip; the next token run relocks.
- Async reset mid-lock: assert rst_n=0 between clock edges. Required: locked, VDE, VD, CD, bitslip go to 0 immediately; after release, relock needs a full run of 8 tokens.
